// File: rtl/prbs10_checker.sv
// Self-synchronising checker for the 10-bit PRBS (x^10 family) serial stream.
// Hunts for LOCK_COUNT consecutive correct predictions, then counts bit errors until a window shows too many.
module prbs10_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_WINDOW = 32,
  parameter int LOSS_ERRS   = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Data_in,
  input  logic             Data_valid,
  input  logic             Clear_count,
  output logic             Locked,
  output logic             Bit_error,
  output logic [ERR_W-1:0] Err_count
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int EW = $clog2(LOSS_ERRS + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [9:0]      hist;
  logic [3:0]      fill;
  logic [MW-1:0]   match_cnt, match_nxt;
  logic [WW-1:0]   win_cnt, win_nxt;
  logic [EW-1:0]   win_err, win_err_nxt;
  logic            pred, cmp_ok, mism, err_flag;

  // hist[k] is the bit accepted k+1 accepts before the incoming one
  assign pred     = hist[1] ^ hist[2] ^ hist[3] ^ hist[7] ^ hist[9];
  assign cmp_ok   = Data_valid && (fill == 4'd10);
  assign mism     = cmp_ok && (Data_in != pred);
  assign err_flag = mism && (state == LOCKED);
  assign Locked   = (state == LOCKED);

  always_comb begin
    state_nxt   = state;
    match_nxt   = match_cnt;
    win_nxt     = win_cnt;
    win_err_nxt = win_err;
    case (state)
      HUNT: if (cmp_ok) begin
        // an all-zero history predicts zero forever, so it never counts toward lock
        if (mism || hist == '0) begin
          match_nxt = '0;
        end else if (match_cnt == MW'(LOCK_COUNT - 1)) begin
          state_nxt   = LOCKED;
          match_nxt   = '0;
          win_nxt     = '0;
          win_err_nxt = '0;
        end else begin
          match_nxt = match_cnt + MW'(1);
        end
      end
      LOCKED: if (Data_valid) begin
        if (mism && win_err == EW'(LOSS_ERRS - 1)) begin
          state_nxt = HUNT;
          match_nxt = '0;
        end else if (win_cnt == WW'(LOSS_WINDOW - 1)) begin
          win_nxt     = '0;
          win_err_nxt = '0;
        end else begin
          win_nxt     = win_cnt + WW'(1);
          win_err_nxt = win_err + EW'(mism);
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      Bit_error <= 1'b0;
      Err_count <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      win_cnt   <= win_nxt;
      win_err   <= win_err_nxt;
      Bit_error <= err_flag;
      if (Data_valid) begin
        hist <= {hist[8:0], Data_in};
        if (fill != 4'd10) fill <= fill + 4'd1;
      end
      // clear wins over a same-cycle error; the pulse above is unaffected
      if (Clear_count)
        Err_count <= '0;
      else if (err_flag && Err_count != '1)
        Err_count <= Err_count + ERR_W'(1);
    end
  end
endmodule

// File: tb/tb_prbs10_checker.sv
// Randomised bench for prbs10_checker: a bit-list reference model plus a PRBS10 generator,
// scenario tasks for lock, single error, all-zero, loss, saturation/clear, gaps and reset.
module tb_prbs10_checker;
  localparam int LOCK_COUNT = 16, LOSS_WINDOW = 32, LOSS_ERRS = 8, ERR_W = 4;

  logic clock = 0, reset = 0, Data_in = 0, Data_valid = 0, Clear_count = 0;
  logic Locked, Bit_error;
  logic [ERR_W-1:0] Err_count;
  int checks = 0, errors = 0;

  prbs10_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_WINDOW(LOSS_WINDOW),
                   .LOSS_ERRS(LOSS_ERRS), .ERR_W(ERR_W)) dut (
    .clock(clock), .reset(reset), .Data_in(Data_in), .Data_valid(Data_valid),
    .Clear_count(Clear_count), .Locked(Locked), .Bit_error(Bit_error), .Err_count(Err_count));

  always #5 clock = ~clock;

  // generator: gq holds the last 10 generated bits, newest at the back
  bit gq[$];
  function automatic bit gen_next();
    bit nb;
    nb = gq[8] ^ gq[7] ^ gq[6] ^ gq[2] ^ gq[0];
    gq.push_back(nb);
    void'(gq.pop_front());
    return nb;
  endfunction

  // reference model: list of the last accepted bits and plain integer counters
  bit mh[$];
  int m_run, m_wpos, m_werr, m_err;
  bit m_locked, m_berr;

  task automatic m_reset();
    mh.delete();
    m_run = 0; m_wpos = 0; m_werr = 0; m_err = 0; m_locked = 0; m_berr = 0;
  endtask

  task automatic m_step(input bit din, input bit dv, input bit clr);
    bit valid, mism, zero, pred;
    valid = dv && mh.size() == 10;
    mism = 0; zero = 1; pred = 0;
    if (valid) begin
      pred = mh[8] ^ mh[7] ^ mh[6] ^ mh[2] ^ mh[0];
      mism = (din != pred);
      foreach (mh[i]) if (mh[i]) zero = 0;
    end
    m_berr = valid && m_locked && mism;
    if (clr) m_err = 0;
    else if (m_berr && m_err < (2**ERR_W) - 1) m_err++;
    if (valid) begin
      if (!m_locked) begin
        if (mism || zero) m_run = 0; else m_run++;
        if (m_run == LOCK_COUNT) begin
          m_locked = 1; m_run = 0; m_wpos = 0; m_werr = 0;
        end
      end else begin
        m_werr += int'(mism);
        if (m_werr == LOSS_ERRS) begin
          m_locked = 0; m_run = 0;
        end else begin
          m_wpos++;
          if (m_wpos == LOSS_WINDOW) begin m_wpos = 0; m_werr = 0; end
        end
      end
    end
    if (dv) begin
      mh.push_back(din);
      if (mh.size() > 10) void'(mh.pop_front());
    end
  endtask

  task automatic cyc(input bit din, input bit dv, input bit clr);
    Data_in = din; Data_valid = dv; Clear_count = clr;
    @(posedge clock);
    m_step(din, dv, clr);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 0; Data_valid = 0; Clear_count = 0;
    m_reset();
    #2 reset = 1;
  endtask

  task automatic run_gen(input int n);
    for (int i = 0; i < n; i++) cyc(gen_next(), 1, 0);
  endtask

  task automatic test_reset();
    reset = 0; #3;
    checks++;
    if (Locked !== 1'b0 || Bit_error !== 1'b0 || Err_count !== '0) begin
      errors++;
      $display("FAIL reset_state: got L=%b BE=%b EC=%0d want 0 0 0", Locked, Bit_error, Err_count);
    end
    m_reset();
    #2 reset = 1;
  endtask

  task automatic test_lock_acquire();
    for (int i = 1; i <= 26; i++) begin
      cyc(gen_next(), 1, 0);
      checks++;
      if (Locked !== (i == 26) || Locked !== m_locked) begin
        errors++;
        $display("FAIL lock_acq edge %0d: Locked=%b want %b", i, Locked, (i == 26));
      end
    end
    for (int i = 0; i < 1000; i++) begin
      cyc(gen_next(), 1, 0);
      checks++;
      if (Bit_error !== 1'b0 || Err_count !== '0 || Locked !== 1'b1) begin
        errors++;
        $display("FAIL clean_run cyc %0d: L=%b BE=%b EC=%0d want 1 0 0", i, Locked, Bit_error, Err_count);
      end
    end
  endtask

  task automatic test_single_error();
    bit b, want;
    cyc(gen_next(), 1, 1);
    for (int j = 0; j <= 12; j++) begin
      b = gen_next();
      if (j == 0) b = ~b;
      cyc(b, 1, 0);
      want = (j == 0 || j == 2 || j == 3 || j == 4 || j == 8 || j == 10);
      checks++;
      if (Bit_error !== want || Bit_error !== m_berr) begin
        errors++;
        $display("FAIL single_err offset %0d: Bit_error=%b want %b", j, Bit_error, want);
      end
    end
    checks++;
    if (Err_count !== 4'd6 || Locked !== 1'b1) begin
      errors++;
      $display("FAIL single_err totals: EC=%0d L=%b want 6 1", Err_count, Locked);
    end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 1, 0);
      checks++;
      if (Locked !== 1'b0 || Err_count !== '0 || Bit_error !== 1'b0 || Locked !== m_locked) begin
        errors++;
        $display("FAIL all_zero cyc %0d: L=%b EC=%0d BE=%b want 0 0 0", i, Locked, Err_count, Bit_error);
      end
    end
  endtask

  task automatic test_loss();
    int n, held;
    bit lost;
    do_reset();
    run_gen(26);
    checks++;
    if (Locked !== 1'b1) begin errors++; $display("FAIL loss_prelock: Locked=%b want 1", Locked); end
    lost = 0;
    for (n = 0; n < 300 && !lost; n++) begin
      cyc(1'($urandom_range(0, 1)), 1, 0);
      checks++;
      if (Locked !== m_locked || Bit_error !== m_berr || Err_count !== ERR_W'(m_err)) begin
        errors++;
        $display("FAIL loss_rand cyc %0d: L=%b BE=%b EC=%0d want %b %b %0d",
                 n, Locked, Bit_error, Err_count, m_locked, m_berr, m_err);
      end
      if (!m_locked) lost = 1;
    end
    checks++;
    if (!lost || Locked !== 1'b0) begin
      errors++; $display("FAIL loss_timeout: Locked=%b want 0 within 300 cycles", Locked);
    end
    held = m_err;
    for (int i = 0; i < 50; i++) begin
      cyc(1'($urandom_range(0, 1)), 1, 0);
      if (!m_locked) begin
        checks++;
        if (Err_count !== ERR_W'(held) || Bit_error !== 1'b0) begin
          errors++; $display("FAIL hunt_hold cyc %0d: EC=%0d BE=%b want %0d 0", i, Err_count, Bit_error, held);
        end
      end
    end
    for (n = 0; n < 60 && !m_locked; n++) begin
      cyc(gen_next(), 1, 0);
      checks++;
      if (Locked !== m_locked) begin
        errors++; $display("FAIL relock cyc %0d: Locked=%b want %b", n, Locked, m_locked);
      end
    end
    checks++;
    if (Locked !== 1'b1) begin errors++; $display("FAIL relock_timeout: Locked=%b want 1", Locked); end
  endtask

  task automatic test_saturate_clear();
    bit b;
    do_reset();
    run_gen(26);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 40; j++) begin
        b = gen_next();
        if (j == 0) b = ~b;
        cyc(b, 1, 0);
        checks++;
        if (Err_count !== ERR_W'(m_err) || Bit_error !== m_berr || Locked !== 1'b1) begin
          errors++;
          $display("FAIL sat_run r%0d j%0d: EC=%0d BE=%b L=%b want %0d %b 1",
                   r, j, Err_count, Bit_error, Locked, m_err, m_berr);
        end
      end
    checks++;
    if (Err_count !== 4'd15) begin errors++; $display("FAIL saturate: EC=%0d want 15", Err_count); end
    cyc(~gen_next(), 1, 1);
    checks++;
    if (Err_count !== 4'd0 || Bit_error !== 1'b1) begin
      errors++; $display("FAIL clear_prio: EC=%0d BE=%b want 0 1", Err_count, Bit_error);
    end
  endtask

  task automatic test_gaps_and_reset();
    bit dv;
    int acc;
    do_reset();
    run_gen(26);
    for (int i = 0; i < 200; i++) begin
      dv = 1'($urandom_range(0, 1));
      cyc(dv ? gen_next() : 1'($urandom_range(0, 1)), dv, 0);
      checks++;
      if (Locked !== 1'b1 || Bit_error !== 1'b0 || Err_count !== '0) begin
        errors++; $display("FAIL gaps cyc %0d: L=%b BE=%b EC=%0d want 1 0 0", i, Locked, Bit_error, Err_count);
      end
    end
    @(posedge clock); #1;
    reset = 0; m_reset(); #1;
    checks++;
    if (Locked !== 1'b0) begin errors++; $display("FAIL midlock_reset: Locked=%b want 0", Locked); end
    #1 reset = 1;
    acc = 0;
    for (int i = 0; i < 200 && acc < 30; i++) begin
      dv = 1'($urandom_range(0, 1));
      cyc(dv ? gen_next() : 1'($urandom_range(0, 1)), dv, 0);
      if (dv) acc++;
      checks++;
      if (Locked !== (acc >= 26) || Locked !== m_locked) begin
        errors++; $display("FAIL relock_gaps acc %0d: Locked=%b want %b", acc, Locked, (acc >= 26));
      end
    end
    checks++;
    if (acc < 30) begin errors++; $display("FAIL relock_gaps_budget: accepted=%0d want 30", acc); end
  endtask

  initial begin
    for (int i = 0; i < 10; i++) gq.push_back(1'($urandom_range(0, 1)));
    gq[0] = 1'b1;
    test_reset();
    test_lock_acquire();
    test_single_error();
    test_all_zero();
    test_loss();
    test_saturate_clear();
    test_gaps_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
